lc4_regfile_nway: RTL and testbench

Parametrised N-way register file with per-register busy scoreboard for the superscalar LC4 datapath. It sits between decode and writeback. Each of NUM_WAYS slots has two read ports, one write port and one busy-allocate port, so one instance serves 2-, 3- or 4-wide pipelines. Way 0 is the oldest instruction in program order and way NUM_WAYS-1 is the youngest.

---
 rtl/lc4_regfile_nway.sv | 84 ++++++++
 tb/tb_lc4_regfile_nway.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc4_regfile_nway.sv
// N-way LC4 register file with per-register busy scoreboard; highest-index way wins write conflicts.
// Optional write-through bypass is compiled in with `define REGFILE_BYPASS_EN.
module lc4_regfile_nway #(
    parameter int NUM_WAYS = 2,
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       gwe,
    input  logic [NUM_WAYS*AW-1:0]     i_rs,
    input  logic [NUM_WAYS*AW-1:0]     i_rt,
    output logic [NUM_WAYS*DATA_W-1:0] o_rs_data,
    output logic [NUM_WAYS*DATA_W-1:0] o_rt_data,
    output logic [NUM_WAYS-1:0]        o_rs_busy,
    output logic [NUM_WAYS-1:0]        o_rt_busy,
    input  logic [NUM_WAYS*AW-1:0]     i_rd,
    input  logic [NUM_WAYS-1:0]        i_rd_we,
    input  logic [NUM_WAYS*DATA_W-1:0] i_wdata,
    input  logic [NUM_WAYS-1:0]        i_alloc,
    input  logic [NUM_WAYS*AW-1:0]     i_alloc_reg
);

    logic [DATA_W-1:0]   regs      [NUM_REGS];
    logic [DATA_W-1:0]   regs_next [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    // Later ways overwrite earlier ones; allocates are applied after clears so set wins.
    always_comb begin
        regs_next = regs;
        busy_next = busy;
        for (int k = 0; k < NUM_WAYS; k++) begin
            if (i_rd_we[k]) begin
                regs_next[i_rd[k*AW +: AW]] = i_wdata[k*DATA_W +: DATA_W];
                busy_next[i_rd[k*AW +: AW]] = 1'b0;
            end
        end
        for (int k = 0; k < NUM_WAYS; k++) begin
            if (i_alloc[k]) begin
                busy_next[i_alloc_reg[k*AW +: AW]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: '0};
            busy <= '0;
        end else if (gwe) begin
            regs <= regs_next;
            busy <= busy_next;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp_ok;
    assign byp_ok = gwe & rst;
`endif

    always_comb begin
        o_rs_data = '0;
        o_rt_data = '0;
        o_rs_busy = '0;
        o_rt_busy = '0;
        for (int k = 0; k < NUM_WAYS; k++) begin
            o_rs_data[k*DATA_W +: DATA_W] = regs[i_rs[k*AW +: AW]];
            o_rt_data[k*DATA_W +: DATA_W] = regs[i_rt[k*AW +: AW]];
            o_rs_busy[k]                  = busy[i_rs[k*AW +: AW]];
            o_rt_busy[k]                  = busy[i_rt[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            // Reset gating keeps reads at zero while reset is held, even with gwe high.
            for (int j = 0; j < NUM_WAYS; j++) begin
                if (byp_ok && i_rd_we[j] && (i_rd[j*AW +: AW] == i_rs[k*AW +: AW]))
                    o_rs_data[k*DATA_W +: DATA_W] = i_wdata[j*DATA_W +: DATA_W];
                if (byp_ok && i_rd_we[j] && (i_rd[j*AW +: AW] == i_rt[k*AW +: AW]))
                    o_rt_data[k*DATA_W +: DATA_W] = i_wdata[j*DATA_W +: DATA_W];
            end
`endif
        end
    end

endmodule

// File: tb/tb_lc4_regfile_nway.sv
// Scoreboard bench for lc4_regfile_nway (2 ways, 8 x 16-bit registers).
// Stimulus pushes per-way expectations tagged with a cycle number; a negedge monitor checks them.
module tb_lc4_regfile_nway;

    localparam int  NW  = 2;
    localparam int  AW  = 3;
    localparam int  DW  = 16;
`ifdef REGFILE_BYPASS_EN
    localparam bit  BYP = 1'b1;
`else
    localparam bit  BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            gwe;
    logic [AW-1:0]   rs_a [NW];
    logic [AW-1:0]   rt_a [NW];
    logic [AW-1:0]   rd_a [NW];
    logic [AW-1:0]   al_a [NW];
    logic [DW-1:0]   wd   [NW];
    logic [NW-1:0]   we;
    logic [NW-1:0]   al;

    logic [NW*AW-1:0] i_rs, i_rt, i_rd, i_alloc_reg;
    logic [NW*DW-1:0] i_wdata, o_rs_data, o_rt_data;
    logic [NW-1:0]    o_rs_busy, o_rt_busy;

    assign i_rs        = {rs_a[1], rs_a[0]};
    assign i_rt        = {rt_a[1], rt_a[0]};
    assign i_rd        = {rd_a[1], rd_a[0]};
    assign i_alloc_reg = {al_a[1], al_a[0]};
    assign i_wdata     = {wd[1], wd[0]};

    lc4_regfile_nway dut (
        .clk        (clk),
        .rst        (rst),
        .gwe        (gwe),
        .i_rs       (i_rs),
        .i_rt       (i_rt),
        .o_rs_data  (o_rs_data),
        .o_rt_data  (o_rt_data),
        .o_rs_busy  (o_rs_busy),
        .o_rt_busy  (o_rt_busy),
        .i_rd       (i_rd),
        .i_rd_we    (we),
        .i_wdata    (i_wdata),
        .i_alloc    (al),
        .i_alloc_reg(i_alloc_reg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          way;
        string       name;
        logic [15:0] rs_d;
        logic [15:0] rt_d;
        logic        rs_b;
        logic        rt_b;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: the DUT output is combinational, so it is presented every cycle at negedge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc) begin
                total++;
                bad++;
                $display("FAIL %s: stale expectation for cycle %0d seen at %0d", e.name, e.cyc, cyc);
            end else begin
                check({e.name, ".rs_data"}, o_rs_data[e.way*DW +: DW], e.rs_d);
                check({e.name, ".rt_data"}, o_rt_data[e.way*DW +: DW], e.rt_d);
                check({e.name, ".rs_busy"}, {15'd0, o_rs_busy[e.way]}, {15'd0, e.rs_b});
                check({e.name, ".rt_busy"}, {15'd0, o_rt_busy[e.way]}, {15'd0, e.rt_b});
            end
        end
    end

    task automatic expect_way(input int w, input string nm, input logic [15:0] rsd,
                              input logic [15:0] rtd, input logic rsb, input logic rtb);
        exp_t e;
        e.cyc  = cyc;
        e.way  = w;
        e.name = nm;
        e.rs_d = rsd;
        e.rt_d = rtd;
        e.rs_b = rsb;
        e.rt_b = rtb;
        q.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        we = '0;
        al = '0;
    endtask

    task automatic rd(input int w, input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        rs_a[w] = rs;
        rt_a[w] = rt;
    endtask

    task automatic wr(input int w, input logic [AW-1:0] r, input logic [15:0] d);
        we[w]   = 1'b1;
        rd_a[w] = r;
        wd[w]   = d;
    endtask

    task automatic alloc(input int w, input logic [AW-1:0] r);
        al[w]   = 1'b1;
        al_a[w] = r;
    endtask

    initial begin
        rst = 1'b0;
        gwe = 1'b1;
        we  = '0;
        al  = '0;
        for (int i = 0; i < NW; i++) begin
            rs_a[i] = '0; rt_a[i] = '0; rd_a[i] = '0; al_a[i] = '0; wd[i] = '0;
        end

        // Reset held for 3 cycles with writes and allocates presented.
        for (int c = 0; c < 3; c++) begin
            next();
            wr(0, 3'd3, 16'h5555);
            wr(1, 3'd6, 16'h6666);
            alloc(0, 3'd1);
            rd(0, 3'd3, 3'd6);
            rd(1, 3'd1, 3'd0);
            expect_way(0, "reset_w0", 16'h0000, 16'h0000, 1'b0, 1'b0);
            expect_way(1, "reset_w1", 16'h0000, 16'h0000, 1'b0, 1'b0);
        end

        next();
        rst = 1'b1;
        rd(0, 3'd3, 3'd6);
        rd(1, 3'd1, 3'd0);
        expect_way(0, "post_reset_w0", 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_way(1, "post_reset_w1", 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Basic write/read.
        next();
        wr(0, 3'd3, 16'h1234);
        wr(1, 3'd5, 16'hABCD);
        rd(0, 3'd3, 3'd5);
        expect_way(0, "basic_same", BYP ? 16'h1234 : 16'h0000, BYP ? 16'hABCD : 16'h0000, 1'b0, 1'b0);
        next();
        rd(1, 3'd3, 3'd5);
        expect_way(1, "basic_next", 16'h1234, 16'hABCD, 1'b0, 1'b0);

        // Write conflict on r2: way1 wins.
        next();
        wr(0, 3'd2, 16'h1111);
        wr(1, 3'd2, 16'h2222);
        rd(0, 3'd2, 3'd3);
        rd(1, 3'd5, 3'd2);
        expect_way(0, "conflict_same_w0", BYP ? 16'h2222 : 16'h0000, 16'h1234, 1'b0, 1'b0);
        expect_way(1, "conflict_same_w1", 16'hABCD, BYP ? 16'h2222 : 16'h0000, 1'b0, 1'b0);
        next();
        rd(0, 3'd2, 3'd2);
        rd(1, 3'd2, 3'd3);
        expect_way(0, "conflict_next_w0", 16'h2222, 16'h2222, 1'b0, 1'b0);
        expect_way(1, "conflict_next_w1", 16'h2222, 16'h1234, 1'b0, 1'b0);

        // Younger-way write seen by older-way read.
        next();
        wr(1, 3'd7, 16'hBEEF);
        rd(0, 3'd7, 3'd5);
        expect_way(0, "bypass_same", BYP ? 16'hBEEF : 16'h0000, 16'hABCD, 1'b0, 1'b0);
        next();
        rd(0, 3'd7, 3'd7);
        expect_way(0, "bypass_next", 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);

        // gwe low: write, allocate and bypass all suppressed.
        next();
        gwe = 1'b0;
        wr(0, 3'd1, 16'hFFFF);
        alloc(0, 3'd1);
        rd(0, 3'd1, 3'd7);
        rd(1, 3'd7, 3'd1);
        expect_way(0, "gwe_low_w0", 16'h0000, 16'hBEEF, 1'b0, 1'b0);
        expect_way(1, "gwe_low_w1", 16'hBEEF, 16'h0000, 1'b0, 1'b0);
        next();
        gwe = 1'b1;
        rd(0, 3'd1, 3'd1);
        expect_way(0, "gwe_after", 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Scoreboard: allocate r4, then write+reallocate, then plain write.
        next();
        alloc(0, 3'd4);
        rd(0, 3'd4, 3'd3);
        expect_way(0, "alloc_pre", 16'h0000, 16'h1234, 1'b0, 1'b0);
        next();
        wr(1, 3'd4, 16'h0042);
        alloc(0, 3'd4);
        rd(0, 3'd4, 3'd3);
        rd(1, 3'd3, 3'd4);
        expect_way(0, "alloc_set_w0", BYP ? 16'h0042 : 16'h0000, 16'h1234, 1'b1, 1'b0);
        expect_way(1, "alloc_set_w1", 16'h1234, BYP ? 16'h0042 : 16'h0000, 1'b0, 1'b1);
        next();
        wr(0, 3'd4, 16'h0099);
        rd(0, 3'd4, 3'd4);
        expect_way(0, "set_wins", BYP ? 16'h0099 : 16'h0042, BYP ? 16'h0099 : 16'h0042, 1'b1, 1'b1);
        next();
        rd(0, 3'd4, 3'd2);
        rd(1, 3'd2, 3'd4);
        expect_way(0, "busy_clear_w0", 16'h0099, 16'h2222, 1'b0, 1'b0);
        expect_way(1, "busy_clear_w1", 16'h2222, 16'h0099, 1'b0, 1'b0);

        // Set wins across ways: way0 writes r6, way1 allocates r6.
        next();
        wr(0, 3'd6, 16'h6006);
        alloc(1, 3'd6);
        rd(0, 3'd6, 3'd0);
        expect_way(0, "xway_pre", BYP ? 16'h6006 : 16'h0000, 16'h0000, 1'b0, 1'b0);
        next();
        rd(0, 3'd6, 3'd0);
        rd(1, 3'd0, 3'd6);
        expect_way(0, "xway_post_w0", 16'h6006, 16'h0000, 1'b1, 1'b0);
        expect_way(1, "xway_post_w1", 16'h0000, 16'h6006, 1'b0, 1'b1);

        // r0 is an ordinary writable register.
        next();
        wr(0, 3'd0, 16'hC0DE);
        next();
        rd(1, 3'd0, 3'd6);
        expect_way(1, "r0_writable", 16'hC0DE, 16'h6006, 1'b0, 1'b1);

        // Reset asserted mid-cycle with a pending write.
        next();
        rst = 1'b0;
        wr(0, 3'd3, 16'h7777);
        rd(0, 3'd3, 3'd6);
        rd(1, 3'd0, 3'd4);
        expect_way(0, "mid_reset_w0", 16'h0000, 16'h0000, 1'b0, 1'b0);
        expect_way(1, "mid_reset_w1", 16'h0000, 16'h0000, 1'b0, 1'b0);
        next();
        rst = 1'b1;
        rd(0, 3'd3, 3'd6);
        expect_way(0, "after_mid_reset", 16'h0000, 16'h0000, 1'b0, 1'b0);

        for (int c = 0; c < 10 && q.size() > 0; c++) @(posedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
